// File: rtl/vga_pkg.sv
// Shared VGA definitions: default active-area size, 12-bit colour type and
// the bounce-colour palette used by the box renderer.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    typedef logic [11:0] rgb12;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_e;

    // Index 0 would be black on black, so it maps to mid-grey instead.
    function automatic rgb12 palette(input logic [2:0] idx);
        if (idx == 3'd0) begin
            return 12'h888;
        end
        return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Frame-tick detector plus the bouncing-box motion and colour state,
// advanced once per frame on the falling edge of Vsync.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       Vsync,
    output logic [9:0] boxX,
    output logic [8:0] boxY,
    output logic [2:0] colorIdx
);

    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] SIZE_W  = 11'(BOX_SIZE);
    localparam logic [10:0] H_LIMIT = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIMIT = 11'(V_ACTIVE);

    logic       vsync_d;
    logic       armed;
    logic       tick;
    logic [9:0] box_x_q, box_x_n;
    logic [8:0] box_y_q, box_y_n;
    dir_e       dir_x_q, dir_x_n;
    dir_e       dir_y_q, dir_y_n;
    logic [2:0] color_q, color_n;
    logic       bounce_x, bounce_y;

    // armed stays low until Vsync is seen high after reset, so a Vsync held
    // low through reset release does not look like a falling edge.
    assign tick = armed & vsync_d & ~Vsync;

    always_ff @(posedge clk_div) begin
        if (rst) begin
            vsync_d <= 1'b1;
            armed   <= 1'b0;
            box_x_q <= '0;
            box_y_q <= '0;
            dir_x_q <= DIR_INC;
            dir_y_q <= DIR_INC;
            color_q <= '0;
        end else begin
            vsync_d <= Vsync;
            armed   <= armed | Vsync;
            box_x_q <= box_x_n;
            box_y_q <= box_y_n;
            dir_x_q <= dir_x_n;
            dir_y_q <= dir_y_n;
            color_q <= color_n;
        end
    end

    always_comb begin
        box_x_n  = box_x_q;
        box_y_n  = box_y_q;
        dir_x_n  = dir_x_q;
        dir_y_n  = dir_y_q;
        color_n  = color_q;
        bounce_x = 1'b0;
        bounce_y = 1'b0;
        if (tick) begin
            if (dir_x_q == DIR_INC) begin
                if ({1'b0, box_x_q} + STEP_W + SIZE_W > H_LIMIT) begin
                    box_x_n  = 10'(H_ACTIVE - BOX_SIZE);
                    dir_x_n  = DIR_DEC;
                    bounce_x = 1'b1;
                end else begin
                    box_x_n = box_x_q + 10'(STEP);
                end
            end else begin
                if ({1'b0, box_x_q} < STEP_W) begin
                    box_x_n  = '0;
                    dir_x_n  = DIR_INC;
                    bounce_x = 1'b1;
                end else begin
                    box_x_n = box_x_q - 10'(STEP);
                end
            end

            if (dir_y_q == DIR_INC) begin
                if ({2'b00, box_y_q} + STEP_W + SIZE_W > V_LIMIT) begin
                    box_y_n  = 9'(V_ACTIVE - BOX_SIZE);
                    dir_y_n  = DIR_DEC;
                    bounce_y = 1'b1;
                end else begin
                    box_y_n = box_y_q + 9'(STEP);
                end
            end else begin
                if ({2'b00, box_y_q} < STEP_W) begin
                    box_y_n  = '0;
                    dir_y_n  = DIR_INC;
                    bounce_y = 1'b1;
                end else begin
                    box_y_n = box_y_q - 9'(STEP);
                end
            end

            if (bounce_x | bounce_y) begin
                color_n = color_q + 3'd1;
            end
        end
    end

    assign boxX     = box_x_q;
    assign boxY     = box_y_q;
    assign colorIdx = color_q;

endmodule

// File: rtl/vga_box_render.sv
// Pixel-colour stage after the VGA timing generator: border, bouncing box and
// background, with syncs delayed through the same two-stage pipeline as RGB.
module vga_box_render
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   BOX_SIZE = 32,
    parameter int   STEP     = 2,
    parameter rgb12 BG_COLOR = 12'h00F
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic [9:0] xPos,
    input  logic [8:0] yPos,
    input  logic       active,
    input  logic       Hsync,
    input  logic       Vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync_out,
    output logic       vsync_out
);

    logic [9:0] box_x;
    logic [8:0] box_y;
    logic [2:0] color_idx;

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_mover (
        .clk_div  (clk_div),
        .rst      (rst),
        .Vsync    (Vsync),
        .boxX     (box_x),
        .boxY     (box_y),
        .colorIdx (color_idx)
    );

    logic       border;
    logic       in_box;
    logic       active_s1, border_s1, in_box_s1, hsync_s1, vsync_s1;
    logic [2:0] color_s1;
    rgb12       pixel;
    rgb12       rgb_q;

    assign border = (xPos == 10'd0) || (xPos == 10'(H_ACTIVE - 1)) ||
                    (yPos == 9'd0)  || (yPos == 9'(V_ACTIVE - 1));

    assign in_box = ({1'b0, xPos} >= {1'b0, box_x}) &&
                    ({1'b0, xPos} <  {1'b0, box_x} + 11'(BOX_SIZE)) &&
                    ({1'b0, yPos} >= {1'b0, box_y}) &&
                    ({1'b0, yPos} <  {1'b0, box_y} + 10'(BOX_SIZE));

    // The colour index is captured alongside in_box so a pixel is always
    // painted with the colour that belonged to the box position it was tested against.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            active_s1 <= 1'b0;
            border_s1 <= 1'b0;
            in_box_s1 <= 1'b0;
            color_s1  <= '0;
            hsync_s1  <= 1'b1;
            vsync_s1  <= 1'b1;
        end else begin
            active_s1 <= active;
            border_s1 <= border;
            in_box_s1 <= in_box;
            color_s1  <= color_idx;
            hsync_s1  <= Hsync;
            vsync_s1  <= Vsync;
        end
    end

    always_comb begin
        pixel = BG_COLOR;
        if (!active_s1) begin
            pixel = 12'h000;
        end else if (border_s1) begin
            pixel = 12'hFFF;
        end else if (in_box_s1) begin
            pixel = palette(color_s1);
        end
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            rgb_q     <= 12'h000;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            rgb_q     <= pixel;
            hsync_out <= hsync_s1;
            vsync_out <= vsync_s1;
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];

endmodule
